// File: rtl/decode_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_pkg: opcodes, ALU-op codes, ID/EX bundle, immediate gen.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package decode_pkg;

  localparam int C_XLEN     = 64;
  localparam int C_NUM_REGS = 32;
  localparam int C_REG_AW   = $clog2(C_NUM_REGS);

  localparam logic [6:0] C_OPC_R     = 7'b0110011;
  localparam logic [6:0] C_OPC_LD    = 7'b0000011;
  localparam logic [6:0] C_OPC_SD    = 7'b0100011;
  localparam logic [6:0] C_OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] C_OPC_OPIMM = 7'b0010011;

  localparam logic [1:0] C_ALU_MEM = 2'b00;
  localparam logic [1:0] C_ALU_BR  = 2'b01;
  localparam logic [1:0] C_ALU_R   = 2'b10;
  localparam logic [1:0] C_ALU_IMM = 2'b11;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_fmt_e;

  typedef struct packed {
    logic [C_XLEN-1:0]   rs1_data;
    logic [C_XLEN-1:0]   rs2_data;
    logic [C_XLEN-1:0]   imm;
    logic [C_REG_AW-1:0] rs1;
    logic [C_REG_AW-1:0] rs2;
    logic [C_REG_AW-1:0] rd;
    logic [3:0]          funct;
    logic [1:0]          alu_op;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_write;
    logic                illegal;
  } id_ex_t;

  // hi = instr[31:20], lo = instr[11:7]; every format is built from these two fields.
  function automatic logic [C_XLEN-1:0] imm_gen(input logic [11:0] hi,
                                                 input logic [4:0]  lo,
                                                 input imm_fmt_e    fmt);
    logic [C_XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{(C_XLEN-12){hi[11]}}, hi};
      IMM_S:   imm = {{(C_XLEN-12){hi[11]}}, hi[11:5], lo};
      IMM_B:   imm = {{(C_XLEN-13){hi[11]}}, hi[11], lo[0], hi[10:5], lo[4:1], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_bypass: 2R/1W register file, x0 hardwired, write-through. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module regfile_bypass #(
  parameter  int XLEN     = 64,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            w_wr_live;

  assign w_wr_live = wr_en_i && (wr_addr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_live) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A write landing this cycle is visible to a same-cycle read.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs1_addr_i == '0) begin
      rs1_data_o = '0;
    end else if (w_wr_live && (wr_addr_i == rs1_addr_i)) begin
      rs1_data_o = wr_data_i;
    end
    if (rs2_addr_i == '0) begin
      rs2_data_o = '0;
    end else if (w_wr_live && (wr_addr_i == rs2_addr_i)) begin
      rs2_data_o = wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_issue_stage: decode, regfile read, load-use stall, ID/EX.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter  int XLEN          = C_XLEN,
  parameter  int NUM_REGS      = C_NUM_REGS,
  parameter  int SUPPORT_ITYPE = 1,
  localparam int REG_AW        = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct,
  output logic [1:0]        ex_alu_op,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_illegal,
  output logic              load_use_stall
);

  id_ex_t          id_ex_q;
  id_ex_t          id_ex_d;
  logic            valid_q;
  imm_fmt_e        w_fmt;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_hazard;
  logic            w_advance;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  regfile_bypass #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (in_instr[15 +: REG_AW]),
    .rs2_addr_i (in_instr[20 +: REG_AW]),
    .rs1_data_o (w_rs1_data),
    .rs2_data_o (w_rs2_data),
    .wr_en_i    (wb_en),
    .wr_addr_i  (wb_rd),
    .wr_data_i  (wb_data)
  );

  always_comb begin
    id_ex_d       = '0;
    w_fmt         = IMM_NONE;
    w_rs1_used    = 1'b0;
    w_rs2_used    = 1'b0;
    id_ex_d.rs1   = in_instr[15 +: C_REG_AW];
    id_ex_d.rs2   = in_instr[20 +: C_REG_AW];
    id_ex_d.rd    = in_instr[7 +: C_REG_AW];
    id_ex_d.funct = {in_instr[30], in_instr[14:12]};
    case (in_instr[6:0])
      C_OPC_R: begin
        id_ex_d.alu_op    = C_ALU_R;
        id_ex_d.reg_write = 1'b1;
        w_rs1_used        = 1'b1;
        w_rs2_used        = 1'b1;
      end
      C_OPC_LD: begin
        id_ex_d.alu_op     = C_ALU_MEM;
        id_ex_d.mem_read   = 1'b1;
        id_ex_d.mem_to_reg = 1'b1;
        id_ex_d.alu_src    = 1'b1;
        id_ex_d.reg_write  = 1'b1;
        w_fmt              = IMM_I;
        w_rs1_used         = 1'b1;
      end
      C_OPC_SD: begin
        id_ex_d.alu_op    = C_ALU_MEM;
        id_ex_d.mem_write = 1'b1;
        id_ex_d.alu_src   = 1'b1;
        w_fmt             = IMM_S;
        w_rs1_used        = 1'b1;
        w_rs2_used        = 1'b1;
      end
      C_OPC_BEQ: begin
        id_ex_d.alu_op = C_ALU_BR;
        id_ex_d.branch = 1'b1;
        w_fmt          = IMM_B;
        w_rs1_used     = 1'b1;
        w_rs2_used     = 1'b1;
      end
      C_OPC_OPIMM: begin
        if (SUPPORT_ITYPE != 0) begin
          id_ex_d.alu_op    = C_ALU_IMM;
          id_ex_d.alu_src   = 1'b1;
          id_ex_d.reg_write = 1'b1;
          w_fmt             = IMM_I;
          w_rs1_used        = 1'b1;
        end else begin
          id_ex_d.illegal = 1'b1;
        end
      end
      default: id_ex_d.illegal = 1'b1;
    endcase
    id_ex_d.imm      = imm_gen(in_instr[31:20], in_instr[11:7], w_fmt);
    id_ex_d.rs1_data = w_rs1_data;
    id_ex_d.rs2_data = w_rs2_data;
  end

  assign w_hazard = in_valid && valid_q && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                    ((w_rs1_used && (id_ex_d.rs1 == id_ex_q.rd)) ||
                     (w_rs2_used && (id_ex_d.rs2 == id_ex_q.rd)));
  assign w_advance = !valid_q || out_ready;

  // A flushed hazard never becomes a bubble, so it is not reported either.
  assign load_use_stall = w_hazard && !flush;
  assign in_ready       = w_advance && !w_hazard && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_ex_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard || !in_valid) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= 1'b1;
        id_ex_q <= id_ex_d;
      end
    end
  end

  assign out_valid     = valid_q;
  assign ex_rs1_data   = id_ex_q.rs1_data;
  assign ex_rs2_data   = id_ex_q.rs2_data;
  assign ex_imm        = id_ex_q.imm;
  assign ex_rs1        = id_ex_q.rs1;
  assign ex_rs2        = id_ex_q.rs2;
  assign ex_rd         = id_ex_q.rd;
  assign ex_funct      = id_ex_q.funct;
  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_branch     = id_ex_q.branch;
  assign ex_mem_read   = id_ex_q.mem_read;
  assign ex_mem_write  = id_ex_q.mem_write;
  assign ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_reg_write  = id_ex_q.reg_write;
  assign ex_illegal    = id_ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_decode_issue_stage: scoreboard bench with a reference model.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_decode_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  logic        in_ready, out_valid, load_use_stall;
  logic [63:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [1:0]  ex_alu_op;
  logic        ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_write, ex_illegal;

  logic        z_in_ready, z_out_valid, z_load_use_stall;
  logic [63:0] z_rs1_data, z_rs2_data, z_imm;
  logic [4:0]  z_rs1, z_rs2, z_rd;
  logic [3:0]  z_funct;
  logic [1:0]  z_alu_op;
  logic        z_branch, z_mem_read, z_mem_write, z_mem_to_reg, z_alu_src, z_reg_write, z_illegal;

  decode_issue_stage #(.XLEN(64), .NUM_REGS(32), .SUPPORT_ITYPE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
  );

  decode_issue_stage #(.XLEN(64), .NUM_REGS(32), .SUPPORT_ITYPE(0)) u_dut_noi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(z_in_ready),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .ex_rs1_data(z_rs1_data), .ex_rs2_data(z_rs2_data), .ex_imm(z_imm),
    .ex_rs1(z_rs1), .ex_rs2(z_rs2), .ex_rd(z_rd), .ex_funct(z_funct), .ex_alu_op(z_alu_op),
    .ex_branch(z_branch), .ex_mem_read(z_mem_read), .ex_mem_write(z_mem_write),
    .ex_mem_to_reg(z_mem_to_reg), .ex_alu_src(z_alu_src), .ex_reg_write(z_reg_write),
    .ex_illegal(z_illegal), .load_use_stall(z_load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    logic        br, mr, mw, m2r, asrc, rw, ill, use2;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [63:0] m_regs[32];
  bit          m_ex_valid, m_ex_load;
  logic [4:0]  m_ex_rd;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sext(input int unsigned v, input int bits);
    longint r;
    r = longint'(v);
    if (v >= (32'd1 << (bits - 1))) r = r - (longint'(1) << bits);
    return r;
  endfunction

  function automatic logic [63:0] rd_model(input logic [4:0] idx, input bit we,
                                           input logic [4:0] wrd, input logic [63:0] wd);
    if (idx == 5'd0) return 64'd0;
    if (we && wrd == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] i, input bit we,
                                        input logic [4:0] wrd, input logic [63:0] wd);
    exp_t e;
    e       = '0;
    e.rs1   = i[19:15];
    e.rs2   = i[24:20];
    e.rd    = i[11:7];
    e.funct = {i[30], i[14:12]};
    case (i[6:0])
      7'b0110011: begin e.aluop = 2'd2; e.rw = 1; e.use2 = 1; end
      7'b0000011: begin e.mr = 1; e.m2r = 1; e.asrc = 1; e.rw = 1; e.imm = sext(i[31:20], 12); end
      7'b0100011: begin e.mw = 1; e.asrc = 1; e.use2 = 1; e.imm = sext({i[31:25], i[11:7]}, 12); end
      7'b1100011: begin
        e.aluop = 2'd1; e.br = 1; e.use2 = 1;
        e.imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      end
      7'b0010011: begin e.aluop = 2'd3; e.asrc = 1; e.rw = 1; e.imm = sext(i[31:20], 12); end
      default:    e.ill = 1;
    endcase
    e.rs1d = rd_model(e.rs1, we, wrd, wd);
    e.rs2d = rd_model(e.rs2, we, wrd, wd);
    return e;
  endfunction

  task automatic cmp_out(input string nm, input exp_t e);
    exp_t a;
    bit   ok;
    a = '0;
    a.rs1d = ex_rs1_data; a.rs2d = ex_rs2_data; a.imm = ex_imm;
    a.rs1 = ex_rs1; a.rs2 = ex_rs2; a.rd = ex_rd; a.funct = ex_funct; a.aluop = ex_alu_op;
    a.br = ex_branch; a.mr = ex_mem_read; a.mw = ex_mem_write; a.m2r = ex_mem_to_reg;
    a.asrc = ex_alu_src; a.rw = ex_reg_write; a.ill = ex_illegal;
    ok = (a.ill == e.ill) && (a.br == e.br) && (a.mr == e.mr) && (a.mw == e.mw) &&
         (a.m2r == e.m2r) && (a.asrc == e.asrc) && (a.rw == e.rw) && (a.aluop == e.aluop) &&
         (a.rs1 == e.rs1) && (a.rs2 == e.rs2) && (a.rd == e.rd) && (a.funct == e.funct);
    if (!e.ill) ok = ok && (a.rs1d == e.rs1d) && (a.imm == e.imm) && (!e.use2 || a.rs2d == e.rs2d);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b alu=%b rs=%0d/%0d rd=%0d f=%h d1=%h d2=%h imm=%h; expected ctl=%b alu=%b rs=%0d/%0d rd=%0d f=%h d1=%h d2=%h imm=%h",
               nm, {a.br, a.mr, a.mw, a.m2r, a.asrc, a.rw, a.ill}, a.aluop, a.rs1, a.rs2, a.rd, a.funct,
               a.rs1d, a.rs2d, a.imm, {e.br, e.mr, e.mw, e.m2r, e.asrc, e.rw, e.ill}, e.aluop,
               e.rs1, e.rs2, e.rd, e.funct, e.rs1d, e.rs2d, e.imm);
    end
  endtask

  // One cycle of stimulus; the model predicts combinational outputs and what ID/EX loads.
  task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit ordy,
                      input bit fl, input bit we, input logic [4:0] wrd, input logic [63:0] wd);
    exp_t e;
    bit   hz, adv;
    @(negedge clk);
    rst = r; in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    #1;
    e   = model_decode(ins, we, wrd, wd);
    hz  = iv && m_ex_valid && m_ex_load && (m_ex_rd != 5'd0) &&
          !e.ill && ((e.rs1 == m_ex_rd) || (e.use2 && e.rs2 == m_ex_rd));
    adv = !m_ex_valid || ordy;
    chk("out_valid", out_valid, m_ex_valid);
    chk("load_use_stall", load_use_stall, hz && !fl);
    chk("in_ready", in_ready, adv && !hz && !fl && !r);
    if (r) begin
      m_ex_valid = 0;
      for (int k = 0; k < 32; k++) m_regs[k] = 64'd0;
    end else begin
      if (fl) m_ex_valid = 0;
      else if (adv) begin
        if (hz || !iv) m_ex_valid = 0;
        else begin
          exp_q.push_back(e);
          m_ex_valid = 1; m_ex_load = e.mr; m_ex_rd = e.rd;
        end
      end
      if (we && wrd != 5'd0) m_regs[wrd] = wd;
    end
  endtask

  task automatic idle(input bit we, input logic [4:0] wrd, input logic [63:0] wd);
    step(0, 0, 32'd0, 1, 0, we, wrd, wd);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] o);
    return {o[12], o[10:5], rs2, rs1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: w[6:0] = 7'b0110011;
      3, 4:    w[6:0] = 7'b0000011;
      5:       w[6:0] = 7'b0100011;
      6:       w[6:0] = 7'b1100011;
      7, 8:    w[6:0] = 7'b0010011;
      default: ;
    endcase
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Monitor: a new ID/EX presentation pops the scoreboard; a held one must stay equal to it.
  initial begin
    bit   prev_valid;
    exp_t last;
    exp_t e;
    prev_valid = 0;
    last       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && out_valid) begin
        if (!prev_valid || out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_issue: got out_valid=1 expected no pending instruction");
          end else begin
            e = exp_q.pop_front();
            cmp_out("issue", e);
            last = e;
          end
        end else begin
          cmp_out("hold_stable", last);
        end
      end
      prev_valid = mon_en && out_valid;
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_instr = 0; out_ready = 1; flush = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    m_ex_valid = 0; m_ex_load = 0; m_ex_rd = 0;
    for (int k = 0; k < 32; k++) m_regs[k] = 64'd0;
    repeat (2) @(posedge clk);
    mon_en = 1;

    step(1, 1, enc_r(5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_imm", ex_imm, 0);
    chk("reset_data", ex_rs1_data | ex_rs2_data, 0);
    chk("reset_ctl", {ex_rs1, ex_rs2, ex_rd, ex_funct, ex_alu_op, ex_branch, ex_mem_read,
                      ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_write, ex_illegal}, 0);

    step(0, 1, enc_i(7'b0010011, 5'd1, 5'd0, 12'd5), 1, 0, 0, 0, 0);
    idle(0, 0, 0);
    chk("addi_imm", ex_imm, 64'd5);
    chk("addi_alu_op", ex_alu_op, 2'b11);
    chk("addi_alu_src", ex_alu_src, 1);
    chk("noi_valid", z_out_valid, 1);
    chk("noi_illegal", z_illegal, 1);
    chk("noi_reg_write", z_reg_write, 0);

    idle(1, 5'd2, 64'd100);
    idle(1, 5'd1, 64'd7);
    step(0, 1, enc_i(7'b0000011, 5'd5, 5'd2, 12'd8), 1, 0, 0, 0, 0);
    step(0, 1, enc_r(5'd6, 5'd5, 5'd1), 1, 0, 0, 0, 0);
    chk("lu_stall", load_use_stall, 1);
    step(0, 1, enc_r(5'd6, 5'd5, 5'd1), 1, 0, 1, 5'd5, 64'h1234_5678_9abc_def0);
    chk("lu_bubble", out_valid, 0);
    idle(0, 0, 0);
    chk("lu_bypass_rs1", ex_rs1_data, 64'h1234_5678_9abc_def0);
    chk("lu_rs2", ex_rs2_data, 64'd7);

    step(0, 1, enc_r(5'd4, 5'd3, 5'd0), 1, 0, 1, 5'd3, 64'hDEAD);
    idle(0, 0, 0);
    chk("bypass_dead", ex_rs1_data, 64'hDEAD);
    chk("bypass_x0", ex_rs2_data, 64'd0);

    idle(1, 5'd0, 64'hFFFF);
    step(0, 1, enc_r(5'd7, 5'd0, 5'd0), 1, 0, 0, 0, 0);
    step(0, 1, enc_b(5'd1, 5'd2, 13'h1FF8), 1, 0, 0, 0, 0);
    chk("x0_read", ex_rs1_data, 64'd0);
    idle(0, 0, 0);
    chk("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_alu_op", ex_alu_op, 2'b01);
    chk("beq_branch", ex_branch, 1);

    step(0, 1, enc_r(5'd6, 5'd1, 5'd2), 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, enc_r(5'd7, 5'd1, 5'd2), 0, 0, 0, 0, 0);
    step(0, 1, enc_r(5'd7, 5'd1, 5'd2), 1, 0, 0, 0, 0);
    idle(0, 0, 0);
    chk("release_rd", ex_rd, 5'd7);

    step(0, 1, enc_i(7'b0000011, 5'd5, 5'd2, 12'd0), 1, 0, 0, 0, 0);
    step(0, 1, enc_r(5'd6, 5'd5, 5'd1), 1, 1, 0, 0, 0);
    idle(0, 0, 0);
    chk("flush_kill", out_valid, 0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 255) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    repeat (3) idle(0, 0, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
